// File: rtl/tinyalu_core_if.sv
// TinyALU request/response bus: operands, opcode and start in; done and result out.
// Pure signal bundle, no logic and no added latency.
// Requester holds start high until it sees done; the ALU side never stalls the bus.
interface tinyalu_core_if #(
    parameter int WIDTH = 9
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         op;
    logic               start;
    logic               done;
    logic [2*WIDTH-1:0] result;

    // Requester side (bus-functional model or testbench).
    modport master (
        output A,
        output B,
        output op,
        output start,
        input  done,
        input  result
    );

    // ALU side.
    modport slave (
        input  A,
        input  B,
        input  op,
        input  start,
        output done,
        output result
    );
endinterface

// File: rtl/tinyalu_core.sv
// TinyALU datapath: add/and/xor in one cycle, mul through a 3-stage pipeline.
// Latency: done 1 cycle after accept for add/and/xor, 3 cycles after accept for mul.
// Backpressure: start is level-held; one op per start level, rearmed only after start drops.
module tinyalu_core #(
    parameter int WIDTH = 9
) (
    input logic           clk,
    input logic           reset,
    tinyalu_core_if.slave bus
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    // Multiplier operand B is split in two halves; each half feeds one partial product.
    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    typedef enum logic [2:0] {
        IDLE,
        MUL1,
        MUL2,
        MUL3,
        WAIT_LOW
    } state_t;

    state_t             state;
    logic               rearm;
    logic               single_pend;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         op_q;
    logic               done_q;
    logic [2*WIDTH-1:0] result_q;

    logic               legal_op;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] alu_res;

    logic [WIDTH+LO_W-1:0] pp_lo;
    logic [WIDTH+HI_W-1:0] pp_hi;
    logic [2*WIDTH-1:0]    prod_q;
    logic                  mul_v1;
    logic                  mul_v2;

    assign bus.done   = done_q;
    assign bus.result = result_q;

    // Only the four arithmetic opcodes start an operation; no_op, rst_op and illegal codes are ignored.
    always_comb begin
        legal_op = 1'b0;
        case (bus.op)
            OP_ADD, OP_AND, OP_XOR, OP_MUL: legal_op = 1'b1;
            default:                        legal_op = 1'b0;
        endcase
    end

    // Single-cycle results, computed from the captured operands, zero-extended to result width.
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = {{(WIDTH-1){1'b0}}, sum};
            OP_AND:  alu_res = {{WIDTH{1'b0}}, a_q & b_q};
            OP_XOR:  alu_res = {{WIDTH{1'b0}}, a_q ^ b_q};
            default: alu_res = '0;
        endcase
    end

    // Control FSM: accept, capture, complete with a one-cycle done, then wait for start to drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rearm       <= 1'b1;
            single_pend <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_NOP;
            done_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (single_pend) begin
                        // Captured add/and/xor completes one cycle after accept.
                        result_q    <= alu_res;
                        done_q      <= 1'b1;
                        single_pend <= 1'b0;
                        if (bus.start) begin
                            state <= WAIT_LOW;
                        end else begin
                            rearm <= 1'b1;
                        end
                    end else if (bus.start && rearm && legal_op) begin
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                        op_q  <= bus.op;
                        rearm <= 1'b0;
                        if (bus.op == OP_MUL) begin
                            state <= MUL1;
                        end else begin
                            single_pend <= 1'b1;
                        end
                    end
                end
                MUL1: state <= MUL2;
                MUL2: state <= MUL3;
                MUL3: begin
                    // Pipeline output is valid here by construction; the valid bit guards the write.
                    if (mul_v2) begin
                        result_q <= prod_q;
                        done_q   <= 1'b1;
                        if (bus.start) begin
                            state <= WAIT_LOW;
                        end else begin
                            rearm <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (!bus.start) begin
                        rearm <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Multiplier pipeline: stage 1 forms two partial products, stage 2 aligns and sums them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_v1 <= 1'b0;
            mul_v2 <= 1'b0;
            pp_lo  <= '0;
            pp_hi  <= '0;
            prod_q <= '0;
        end else begin
            mul_v1 <= (state == MUL1);
            if (state == MUL1) begin
                pp_lo <= {{LO_W{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q[LO_W-1:0]};
                pp_hi <= {{HI_W{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q[WIDTH-1:LO_W]};
            end
            mul_v2 <= mul_v1;
            if (mul_v1) begin
                prod_q <= {{(WIDTH-LO_W){1'b0}}, pp_lo}
                        + ({{(WIDTH-HI_W){1'b0}}, pp_hi} << LO_W);
            end
        end
    end

endmodule
